// File: rtl/rf_scoreboard.sv
// Register-file scoreboard and issue scheduler.
// Tracks in-flight destination registers in program order, blocks issue on
// RAW/WAW hazards or a full tracker, and releases entries in order at GR.
module rf_scoreboard #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned ZERO_REG      = 31,
  parameter bit          RETIRE_BYPASS = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     instn_vld_id,
  input  logic [4:0]               reg_a_id,
  input  logic                     use_a_id,
  input  logic [4:0]               reg_b_id,
  input  logic                     use_b_id,
  input  logic [4:0]               reg_dst_id,
  input  logic                     wr_dst_id,
  input  logic                     i_issue_id,
  input  logic                     retire_gr,
  input  logic                     flush_xx,
  output logic                     issue_ok_id,
  output logic [31:0]              pend_vec_xx,
  output logic [$clog2(DEPTH):0]   inflight_xx,
  output logic                     full_xx,
  output logic                     sb_err_xx
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [4:0]  ZR = 5'(ZERO_REG);

  logic          r_ent_wr  [DEPTH];
  logic [4:0]    r_ent_dst [DEPTH];
  logic [PW:0]   r_rd_ptr;
  logic [PW:0]   r_wr_ptr;
  logic [PW:0]   r_count;
  logic [31:0]   r_pend;
  logic          r_err;

  logic          w_empty;
  logic          w_full;
  logic          w_head_wr;
  logic [4:0]    w_head_dst;
  logic          w_pop;
  logic          w_push;
  logic          w_pop_err;
  logic          w_push_err;
  logic [31:0]   w_clr_mask;
  logic [31:0]   w_set_mask;
  logic [31:0]   w_pend_haz;
  logic          w_hazard;
  logic          w_room;
  logic          w_push_wr;

  assign w_empty    = (r_rd_ptr == r_wr_ptr);
  assign w_full     = (r_rd_ptr[PW-1:0] == r_wr_ptr[PW-1:0]) &&
                      (r_rd_ptr[PW] != r_wr_ptr[PW]);
  assign w_head_wr  = r_ent_wr[r_rd_ptr[PW-1:0]];
  assign w_head_dst = r_ent_dst[r_rd_ptr[PW-1:0]];
  assign w_pop      = retire_gr & ~w_empty;
  assign w_pop_err  = retire_gr & w_empty;
  assign w_push_wr  = wr_dst_id & (reg_dst_id != ZR);

  // Release mask of the retiring head and set mask of the issuing instruction
  always_comb begin
    w_clr_mask = '0;
    w_set_mask = '0;
    if (w_pop && w_head_wr) w_clr_mask = 32'd1 << w_head_dst;
    if (w_push && w_push_wr) w_set_mask = 32'd1 << reg_dst_id;
  end

  // Hazard view of the pending mask; with bypass the retiring head is already free
  always_comb begin
    w_pend_haz = r_pend;
    if (RETIRE_BYPASS) w_pend_haz = r_pend & ~w_clr_mask;
  end

  // Issue decision: purely combinational from current state and ID inputs
  always_comb begin
    w_hazard = (use_a_id  & (reg_a_id   != ZR) & w_pend_haz[reg_a_id])  |
               (use_b_id  & (reg_b_id   != ZR) & w_pend_haz[reg_b_id])  |
               (wr_dst_id & (reg_dst_id != ZR) & w_pend_haz[reg_dst_id]);
    w_room   = ~w_full | (RETIRE_BYPASS & retire_gr);
    issue_ok_id = reset & instn_vld_id & ~w_hazard & w_room;
  end

  assign w_push     = i_issue_id & issue_ok_id;
  assign w_push_err = i_issue_id & ~issue_ok_id;

  // Tracker FIFO, pointers, count, pending mask and sticky error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_ent_wr[i]  <= 1'b0;
        r_ent_dst[i] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_pend   <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= r_err | w_pop_err | w_push_err;
      if (flush_xx) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
        r_pend   <= '0;
      end else begin
        if (w_push) begin
          r_ent_wr[r_wr_ptr[PW-1:0]]  <= w_push_wr;
          r_ent_dst[r_wr_ptr[PW-1:0]] <= reg_dst_id;
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
        // Set applied after clear so a same-register push/pop keeps the bit
        r_pend <= (r_pend & ~w_clr_mask) | w_set_mask;
      end
    end
  end

  assign pend_vec_xx = r_pend;
  assign inflight_xx = r_count;
  assign full_xx     = w_full;
  assign sb_err_xx   = r_err;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Bench for rf_scoreboard: one instance without and one with retire bypass,
// compared against a queue-based reference model of the in-flight list.
module tb_rf_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vld, ua, ub, wd, retire, flush;
  logic [4:0]  ra, rb, rd;
  logic        iss    [2];
  logic        ok_o   [2];
  logic [31:0] pend_o [2];
  logic [2:0]  infl_o [2];
  logic        full_o [2];
  logic        err_o  [2];

  int n_chk = 0;
  int n_err = 0;

  // Reference model: in-flight list as {wr,dst} queues, sticky errors
  logic [5:0] mq0[$];
  logic [5:0] mq1[$];
  logic       merr [2];

  always #5 clk = ~clk;

  rf_scoreboard #(.DEPTH(4), .ZERO_REG(31), .RETIRE_BYPASS(1'b0)) u_dut0 (
    .clk(clk), .reset(rst_n), .instn_vld_id(vld),
    .reg_a_id(ra), .use_a_id(ua), .reg_b_id(rb), .use_b_id(ub),
    .reg_dst_id(rd), .wr_dst_id(wd), .i_issue_id(iss[0]),
    .retire_gr(retire), .flush_xx(flush),
    .issue_ok_id(ok_o[0]), .pend_vec_xx(pend_o[0]), .inflight_xx(infl_o[0]),
    .full_xx(full_o[0]), .sb_err_xx(err_o[0]));

  rf_scoreboard #(.DEPTH(4), .ZERO_REG(31), .RETIRE_BYPASS(1'b1)) u_dut1 (
    .clk(clk), .reset(rst_n), .instn_vld_id(vld),
    .reg_a_id(ra), .use_a_id(ua), .reg_b_id(rb), .use_b_id(ub),
    .reg_dst_id(rd), .wr_dst_id(wd), .i_issue_id(iss[1]),
    .retire_gr(retire), .flush_xx(flush),
    .issue_ok_id(ok_o[1]), .pend_vec_xx(pend_o[1]), .inflight_xx(infl_o[1]),
    .full_xx(full_o[1]), .sb_err_xx(err_o[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int msize(input int b);
    return (b == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [5:0] mget(input int b, input int i);
    return (b == 0) ? mq0[i] : mq1[i];
  endfunction

  // Pending mask = OR of written destinations still in the list (optionally skipping head)
  function automatic logic [31:0] mpend(input int b, input int skip);
    logic [31:0] p = '0;
    logic [5:0]  e;
    for (int i = skip; i < msize(b); i++) begin
      e = mget(b, i);
      if (e[5]) p[e[4:0]] = 1'b1;
    end
    return p;
  endfunction

  function automatic logic mok(input int b);
    logic [31:0] p;
    logic        haz;
    int          skip;
    skip = (b == 1 && retire && msize(b) > 0) ? 1 : 0;
    p    = mpend(b, skip);
    haz  = (ua && ra != 5'd31 && p[ra]) || (ub && rb != 5'd31 && p[rb]) ||
           (wd && rd != 5'd31 && p[rd]);
    return rst_n && vld && !haz && (msize(b) < 4 || (b == 1 && retire));
  endfunction

  function automatic void mclear();
    mq0.delete();
    mq1.delete();
  endfunction

  task automatic idle_in();
    vld = 0; ua = 0; ub = 0; wd = 0; retire = 0; flush = 0;
    ra = '0; rb = '0; rd = '0;
  endtask

  // One cycle: inputs already set at the falling edge; mode 0 none, 1 issue when allowed, 2 force issue
  task automatic tick(input int mode);
    logic       ok [2];
    logic [5:0] ent;
    for (int b = 0; b < 2; b++) begin
      ok[b]  = mok(b);
      iss[b] = (mode == 1) ? ok[b] : (mode == 2);
    end
    #1;
    for (int b = 0; b < 2; b++) begin
      chk($sformatf("issue_ok%0d", b), 32'(ok_o[b]),   32'(ok[b]));
      chk($sformatf("pend%0d", b),     pend_o[b],      mpend(b, 0));
      chk($sformatf("inflight%0d", b), 32'(infl_o[b]), 32'(msize(b)));
      chk($sformatf("full%0d", b),     32'(full_o[b]), 32'(msize(b) == 4));
      chk($sformatf("err%0d", b),      32'(err_o[b]),  32'(merr[b]));
    end
    for (int b = 0; b < 2; b++) begin
      if (retire && msize(b) == 0) merr[b] = 1'b1;
      if (iss[b] && !ok[b])        merr[b] = 1'b1;
      ent = {wd && rd != 5'd31, rd};
      if (flush) begin
        if (b == 0) mq0.delete(); else mq1.delete();
      end else begin
        if (retire && msize(b) > 0) begin
          if (b == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
        end
        if (iss[b] && ok[b]) begin
          if (b == 0) mq0.push_back(ent); else mq1.push_back(ent);
        end
      end
    end
    @(negedge clk);
    iss[0] = 0;
    iss[1] = 0;
  endtask

  function automatic logic [4:0] rnd_reg();
    return ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
  endfunction

  task automatic rnd_cycles(input int n, input bit allow_err);
    for (int k = 0; k < n; k++) begin
      vld = ($urandom_range(0, 4) != 0);
      ra = rnd_reg(); rb = rnd_reg(); rd = rnd_reg();
      ua = $urandom_range(0, 1); ub = $urandom_range(0, 1); wd = $urandom_range(0, 3) != 0;
      retire = ($urandom_range(0, 2) == 0);
      if (!allow_err && (msize(0) == 0 || msize(1) == 0)) retire = 0;
      flush = ($urandom_range(0, 40) == 0);
      tick((allow_err && $urandom_range(0, 15) == 0) ? 2 : 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; iss[0] = 0; iss[1] = 0; merr[0] = 0; merr[1] = 0;
    idle_in();
    vld = 1;
    #2;
    for (int b = 0; b < 2; b++) begin
      chk("rst_ok",   32'(ok_o[b]),   0);
      chk("rst_pend", pend_o[b],      0);
      chk("rst_infl", 32'(infl_o[b]), 0);
      chk("rst_full", 32'(full_o[b]), 0);
      chk("rst_err",  32'(err_o[b]),  0);
    end
    @(negedge clk);
    rst_n = 1;
    idle_in();

    // RAW on r3
    vld = 1; rd = 3; wd = 1; tick(1);
    idle_in(); vld = 1; ua = 1; ra = 3;
    tick(1); tick(1);
    chk("raw_blk0", 32'(ok_o[0]), 0);
    retire = 1; tick(1);
    retire = 0; tick(1);
    flush = 1; idle_in(); flush = 1; tick(0); idle_in();

    // Fill with r1..r4
    for (int i = 1; i <= 4; i++) begin
      vld = 1; rd = 5'(i); wd = 1; tick(1);
    end
    idle_in(); vld = 1; ua = 1; ra = 10; rd = 11; wd = 1; #1;
    chk("fill_ok",   32'(ok_o[0]),   0);
    chk("fill_infl", 32'(infl_o[0]), 4);
    chk("fill_full", 32'(full_o[0]), 1);
    tick(0);
    idle_in(); retire = 1; tick(0);
    idle_in(); #1;
    chk("fill_pend", pend_o[0], 32'h0000_001C);
    flush = 1; tick(0); idle_in();

    // Wrap: issue/retire pairs overlapping by one cycle
    for (int i = 0; i < 10; i++) begin
      vld = 1; rd = 5'(5 + i); wd = 1; retire = (i > 0); tick(1);
      chk("wrap_infl", 32'(infl_o[0] <= 3'd2), 1);
    end
    idle_in(); retire = 1; tick(0); idle_in();

    // Zero register and non-writing instructions
    vld = 1; rd = 31; wd = 1; tick(1);
    vld = 1; rd = 7; wd = 0; tick(1);
    idle_in(); vld = 1; ua = 1; ra = 7; #1;
    chk("zr_pend", pend_o[0], 0);
    chk("zr_ok",   32'(ok_o[0]), 1);
    chk("zr_infl", 32'(infl_o[0]), 2);
    tick(0);
    idle_in(); flush = 1; tick(0); idle_in();

    // Flush with three in flight plus concurrent push and pop
    for (int i = 0; i < 3; i++) begin
      vld = 1; rd = 5'(20 + i); wd = 1; tick(1);
    end
    vld = 1; rd = 25; wd = 1; retire = 1; flush = 1; tick(1);
    idle_in(); #1;
    chk("fl_pend", pend_o[0], 0);
    chk("fl_infl", 32'(infl_o[0]), 0);
    chk("fl_err",  32'(err_o[0]), 0);

    // Randomized traffic without protocol errors
    rnd_cycles(400, 1'b0);
    idle_in(); flush = 1; tick(0); idle_in();

    // Retire at empty: sticky error
    retire = 1; tick(0);
    idle_in(); tick(0); tick(0);
    chk("err_sticky", 32'(err_o[0]), 1);

    // Randomized traffic including illegal requests
    rnd_cycles(200, 1'b1);

    // Asynchronous reset mid-sequence
    for (int i = 0; i < 2; i++) begin
      vld = 1; rd = 5'(12 + i); wd = 1; tick(1);
    end
    vld = 1; ua = 1; ra = 2;
    #3 rst_n = 0;
    #1;
    for (int b = 0; b < 2; b++) begin
      chk("arst_ok",   32'(ok_o[b]),   0);
      chk("arst_pend", pend_o[b],      0);
      chk("arst_infl", 32'(infl_o[b]), 0);
      chk("arst_full", 32'(full_o[b]), 0);
      chk("arst_err",  32'(err_o[b]),  0);
    end
    mclear(); merr[0] = 0; merr[1] = 0;
    @(negedge clk);
    rst_n = 1; idle_in();
    rnd_cycles(150, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
